// File: rtl/dircc_avmm_mailbox.sv
// Avalon-MM mailbox bridging a Nios master to a TX Avalon-ST source and an RX Avalon-ST sink.
// Define DIRCC_MAILBOX_IRQ_EN to enable the irq_en control bit and the level interrupt.
module dircc_avmm_mailbox #(
   parameter int DEPTH = 16
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic [1:0]  avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   output logic        avs_readdatavalid,
   output logic        avs_waitrequest,
   output logic [31:0] aso_data,
   output logic        aso_valid,
   input  logic        aso_ready,
   input  logic [31:0] asi_data,
   input  logic        asi_valid,
   output logic        asi_ready,
   output logic        irq
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [31:0]   ID_VALUE   = 32'h4D42_0001;

   logic [31:0]   txMem [DEPTH];
   logic [31:0]   rxMem [DEPTH];
   logic [PW-1:0] txWrPtr_q, txWrPtr_d, txRdPtr_q, txRdPtr_d;
   logic [PW-1:0] rxWrPtr_q, rxWrPtr_d, rxRdPtr_q, rxRdPtr_d;
   logic [CW-1:0] txCount_q, txCount_d, rxCount_q, rxCount_d;
   logic          underflow_q, underflow_d;
   logic          irqEn_q, irqEn_d;
   logic          irq_q, irq_d;
   logic          readValid_q, readValid_d;
   logic [31:0]   readData_q, readData_d;

   logic txFull, rxFull, rxNonEmpty;
   logic wrAccept, rdAccept, ctrlWrite, flush;
   logic txPush, txPop, rxPush, rxPop;
   logic [31:0] statusWord;

   always_comb begin
      txFull     = (txCount_q == FULL_COUNT);
      rxFull     = (rxCount_q == FULL_COUNT);
      rxNonEmpty = (rxCount_q != '0);

      avs_waitrequest = avs_write && (avs_address == 2'd0) && txFull;
      wrAccept  = avs_write && !avs_waitrequest;
      // A simultaneous write wins, so a read only counts when no write is present.
      rdAccept  = avs_read && !avs_write;
      ctrlWrite = wrAccept && (avs_address == 2'd2);
      flush     = ctrlWrite && avs_writedata[2];

      txPush = wrAccept && (avs_address == 2'd0);
      txPop  = (txCount_q != '0) && aso_ready;
      rxPush = asi_valid && !rxFull;
      rxPop  = rdAccept && (avs_address == 2'd0) && rxNonEmpty;

      statusWord = {8'd0, 8'(txCount_q), 8'(rxCount_q), 4'd0,
                    irqEn_q, underflow_q, txFull, rxNonEmpty};

      txWrPtr_d = txWrPtr_q + PW'(txPush);
      txRdPtr_d = txRdPtr_q + PW'(txPop);
      txCount_d = txCount_q + CW'(txPush) - CW'(txPop);
      rxWrPtr_d = rxWrPtr_q + PW'(rxPush);
      rxRdPtr_d = rxRdPtr_q + PW'(rxPop);
      rxCount_d = rxCount_q + CW'(rxPush) - CW'(rxPop);
      if (flush) begin
         txWrPtr_d = '0;
         txRdPtr_d = '0;
         txCount_d = '0;
         rxWrPtr_d = '0;
         rxRdPtr_d = '0;
         rxCount_d = '0;
      end

      underflow_d = underflow_q;
      if (ctrlWrite && avs_writedata[1]) begin
         underflow_d = 1'b0;
      end else if (rdAccept && (avs_address == 2'd0) && !rxNonEmpty) begin
         underflow_d = 1'b1;
      end

`ifdef DIRCC_MAILBOX_IRQ_EN
      irqEn_d = ctrlWrite ? avs_writedata[0] : irqEn_q;
      irq_d   = irqEn_q && (rxNonEmpty || underflow_q);
`else
      irqEn_d = 1'b0;
      irq_d   = 1'b0;
`endif

      readValid_d = rdAccept;
      readData_d  = '0;
      if (rdAccept) begin
         case (avs_address)
            2'd0:    readData_d = rxNonEmpty ? rxMem[rxRdPtr_q] : 32'd0;
            2'd1:    readData_d = statusWord;
            2'd2:    readData_d = {31'd0, irqEn_q};
            default: readData_d = ID_VALUE;
         endcase
      end
   end

   // Storage arrays carry no reset; the pointers alone define what is valid.
   always_ff @(posedge clk_clk) begin
      if (txPush) txMem[txWrPtr_q] <= avs_writedata;
      if (rxPush) rxMem[rxWrPtr_q] <= asi_data;
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         txWrPtr_q   <= '0;
         txRdPtr_q   <= '0;
         txCount_q   <= '0;
         rxWrPtr_q   <= '0;
         rxRdPtr_q   <= '0;
         rxCount_q   <= '0;
         underflow_q <= 1'b0;
         irqEn_q     <= 1'b0;
         irq_q       <= 1'b0;
         readValid_q <= 1'b0;
         readData_q  <= '0;
      end else begin
         txWrPtr_q   <= txWrPtr_d;
         txRdPtr_q   <= txRdPtr_d;
         txCount_q   <= txCount_d;
         rxWrPtr_q   <= rxWrPtr_d;
         rxRdPtr_q   <= rxRdPtr_d;
         rxCount_q   <= rxCount_d;
         underflow_q <= underflow_d;
         irqEn_q     <= irqEn_d;
         irq_q       <= irq_d;
         readValid_q <= readValid_d;
         readData_q  <= readData_d;
      end
   end

   assign avs_readdata      = readData_q;
   assign avs_readdatavalid = readValid_q;
   assign aso_valid         = (txCount_q != '0);
   assign aso_data          = txMem[txRdPtr_q];
   assign asi_ready         = !rxFull;
   assign irq               = irq_q;

endmodule

// File: tb/tb_dircc_avmm_mailbox.sv
// Self-checking bench for dircc_avmm_mailbox: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations. Honours DIRCC_MAILBOX_IRQ_EN if defined.
module tb_dircc_avmm_mailbox;

   localparam int DEPTH = 16;
   localparam logic [31:0] ID_VALUE = 32'h4D42_0001;
`ifdef DIRCC_MAILBOX_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_reset;
   logic [1:0]  avs_address;
   logic        avs_read, avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   logic        avs_readdatavalid, avs_waitrequest;
   logic [31:0] aso_data;
   logic        aso_valid, aso_ready;
   logic [31:0] asi_data;
   logic        asi_valid, asi_ready;
   logic        irq;

   int checks = 0;
   int failures = 0;
   bit checking = 1'b0;

   logic [31:0] txQ[$];
   logic [31:0] rxQ[$];
   logic [31:0] beatQ[$];
   bit          mUnderflow, mIrqEn, expRdValid, expIrq;
   logic [31:0] expRdData;

   always #5 clk = ~clk;

   dircc_avmm_mailbox #(.DEPTH(DEPTH)) dut (
      .clk_clk(clk), .reset_reset(reset_reset),
      .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
      .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest),
      .aso_data(aso_data), .aso_valid(aso_valid), .aso_ready(aso_ready),
      .asi_data(asi_data), .asi_valid(asi_valid), .asi_ready(asi_ready),
      .irq(irq)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: what each register-map access and stream handshake must do this edge.
   task automatic modelStep();
      logic [31:0] statusWord;
      bit txWait, rxCanPush, doFlush, irqNext;
      if (reset_reset) begin
         txQ.delete();
         rxQ.delete();
         mUnderflow = 0;
         mIrqEn     = 0;
         expRdValid = 0;
         expRdData  = '0;
         expIrq     = 0;
         return;
      end
      statusWord = {8'd0, 8'(txQ.size()), 8'(rxQ.size()), 4'd0,
                    mIrqEn, mUnderflow, (txQ.size() == DEPTH), (rxQ.size() != 0)};
      irqNext   = IRQ_ON && mIrqEn && ((rxQ.size() != 0) || mUnderflow);
      txWait    = avs_write && (avs_address == 2'd0) && (txQ.size() == DEPTH);
      rxCanPush = asi_valid && (rxQ.size() < DEPTH);
      doFlush   = 0;
      expRdValid = 0;
      expRdData  = '0;
      if (avs_read && !avs_write) begin
         expRdValid = 1;
         case (avs_address)
            2'd0: if (rxQ.size() > 0) expRdData = rxQ.pop_front();
                  else mUnderflow = 1;
            2'd1: expRdData = statusWord;
            2'd2: expRdData = {31'd0, mIrqEn};
            default: expRdData = ID_VALUE;
         endcase
      end
      if (txQ.size() > 0 && aso_ready) void'(txQ.pop_front());
      if (avs_write && !txWait) begin
         if (avs_address == 2'd0) txQ.push_back(avs_writedata);
         if (avs_address == 2'd2) begin
            if (avs_writedata[1]) mUnderflow = 0;
            if (IRQ_ON) mIrqEn = avs_writedata[0];
            doFlush = avs_writedata[2];
         end
      end
      if (rxCanPush) rxQ.push_back(asi_data);
      if (doFlush) begin
         txQ.delete();
         rxQ.delete();
      end
      expIrq = irqNext;
   endtask

   always @(posedge clk) modelStep();

   // Per-cycle comparison of every output against the model, plus a record of TX beats.
   always @(negedge clk) begin
      if (checking) begin
         checkOutput("waitrequest", {31'd0, avs_waitrequest},
                     {31'd0, avs_write && avs_address == 2'd0 && txQ.size() == DEPTH});
         checkOutput("aso_valid", {31'd0, aso_valid}, {31'd0, txQ.size() != 0});
         if (txQ.size() != 0) checkOutput("aso_data", aso_data, txQ[0]);
         checkOutput("asi_ready", {31'd0, asi_ready}, {31'd0, rxQ.size() != DEPTH});
         checkOutput("readdatavalid", {31'd0, avs_readdatavalid}, {31'd0, expRdValid});
         if (expRdValid) checkOutput("readdata", avs_readdata, expRdData);
         checkOutput("irq", {31'd0, irq}, {31'd0, expIrq});
         if (aso_valid && aso_ready && !reset_reset) beatQ.push_back(aso_data);
      end
   end

   task automatic avsWrite(input logic [1:0] addr, input logic [31:0] data);
      int cyc;
      @(posedge clk); #1;
      avs_address = addr; avs_writedata = data; avs_write = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (avs_waitrequest && cyc < 64) begin
         @(negedge clk);
         cyc++;
      end
      if (avs_waitrequest) begin
         checks++;
         failures++;
         $display("[TB] FAIL write_timeout actual=waitrequest_stuck expected=accepted addr=%0d", addr);
      end
      @(posedge clk); #1;
      avs_write = 1'b0;
   endtask

   task automatic avsRead(input logic [1:0] addr, output logic [31:0] data);
      @(posedge clk); #1;
      avs_address = addr; avs_read = 1'b1;
      @(posedge clk); #1;
      avs_read = 1'b0;
      checkOutput("read_valid_latency", {31'd0, avs_readdatavalid}, 32'd1);
      data = avs_readdata;
   endtask

   task automatic applyStimulus(input logic [31:0] word);
      @(posedge clk); #1;
      asi_valid = 1'b1; asi_data = word;
      @(posedge clk); #1;
      asi_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      reset_reset = 1'b1; avs_address = '0; avs_read = 0; avs_write = 0;
      avs_writedata = '0; aso_ready = 0; asi_data = '0; asi_valid = 0;
      repeat (2) @(posedge clk);
      #1 reset_reset = 1'b0;
      checking = 1'b1;

      // Reset values and read-only ID
      @(negedge clk);
      checkOutput("reset_aso_valid", {31'd0, aso_valid}, 32'd0);
      checkOutput("reset_asi_ready", {31'd0, asi_ready}, 32'd1);
      checkOutput("reset_irq", {31'd0, irq}, 32'd0);
      checkOutput("reset_rdvalid", {31'd0, avs_readdatavalid}, 32'd0);
      avsRead(2'd3, rd);  checkOutput("id_read", rd, 32'h4D42_0001);
      avsRead(2'd1, rd);  checkOutput("status_after_reset", rd, 32'h0);

      // Ordered TX streaming with aso_ready high
      aso_ready = 1'b1;
      beatQ.delete();
      avsWrite(2'd0, 32'h11); avsWrite(2'd0, 32'h22); avsWrite(2'd0, 32'h33);
      repeat (3) @(posedge clk);
      checkOutput("tx_beats", beatQ.size(), 32'd3);
      if (beatQ.size() == 3) begin
         checkOutput("tx_beat0", beatQ[0], 32'h11);
         checkOutput("tx_beat1", beatQ[1], 32'h22);
         checkOutput("tx_beat2", beatQ[2], 32'h33);
      end
      avsRead(2'd1, rd);  checkOutput("status_tx_drained", rd, 32'h0);

      // TX full: 17th write stalls until one beat drains
      #1 aso_ready = 1'b0;
      beatQ.delete();
      for (int i = 0; i < DEPTH; i++) avsWrite(2'd0, 32'h100 + i);
      avsRead(2'd1, rd);  checkOutput("status_tx_full", rd, 32'h0010_0002);
      @(posedge clk); #1;
      avs_address = 2'd0; avs_writedata = 32'h110; avs_write = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("wait_held", {31'd0, avs_waitrequest}, 32'd1);
      end
      @(posedge clk); #1 aso_ready = 1'b1;
      @(negedge clk); checkOutput("wait_before_pop", {31'd0, avs_waitrequest}, 32'd1);
      @(posedge clk); #1 aso_ready = 1'b0;
      @(negedge clk); checkOutput("wait_after_pop", {31'd0, avs_waitrequest}, 32'd0);
      @(posedge clk); #1 avs_write = 1'b0;
      avsRead(2'd1, rd);  checkOutput("status_refilled", rd, 32'h0010_0002);
      #1 aso_ready = 1'b1;
      repeat (20) @(posedge clk);
      checkOutput("wrap_beats", beatQ.size(), 32'd17);
      if (beatQ.size() == 17) begin
         checkOutput("wrap_first", beatQ[0], 32'h100);
         checkOutput("wrap_mid", beatQ[15], 32'h10F);
         checkOutput("wrap_last", beatQ[16], 32'h110);
      end

      // RX read and underflow
      applyStimulus(32'hCAFE);
      avsRead(2'd0, rd);  checkOutput("rx_cafe", rd, 32'hCAFE);
      avsRead(2'd0, rd);  checkOutput("rx_empty_zero", rd, 32'h0);
      avsRead(2'd1, rd);  checkOutput("status_underflow", rd, 32'h4);
      avsWrite(2'd2, 32'h2);
      avsRead(2'd1, rd);  checkOutput("underflow_cleared", rd, 32'h0);

      // Fill RX, reject overflow, then flush
      for (int i = 0; i < DEPTH; i++) begin
         @(posedge clk); #1;
         asi_valid = 1'b1; asi_data = 32'h200 + i;
      end
      @(posedge clk); #1 asi_data = 32'hDEAD;
      @(negedge clk); checkOutput("rx_full_ready", {31'd0, asi_ready}, 32'd0);
      @(posedge clk); #1 asi_valid = 1'b0;
      avsRead(2'd1, rd);  checkOutput("status_rx_full", rd, 32'h0000_1001);
      avsRead(2'd0, rd);  checkOutput("rx_head", rd, 32'h200);
      avsRead(2'd1, rd);  checkOutput("status_rx_15", rd, 32'h0000_0F01);
      avsWrite(2'd2, 32'h4);
      @(negedge clk); checkOutput("flush_ready", {31'd0, asi_ready}, 32'd1);
      avsRead(2'd1, rd);  checkOutput("status_flushed", rd, 32'h0);

      // Simultaneous read and write: write only
      #1 aso_ready = 1'b0;
      @(posedge clk); #1;
      avs_address = 2'd0; avs_writedata = 32'h77; avs_read = 1'b1; avs_write = 1'b1;
      @(posedge clk); #1;
      avs_read = 1'b0; avs_write = 1'b0;
      checkOutput("rw_no_valid", {31'd0, avs_readdatavalid}, 32'd0);
      @(negedge clk); checkOutput("rw_pushed", aso_data, 32'h77);
      #1 aso_ready = 1'b1;
      repeat (2) @(posedge clk);

      // Interrupt
      avsWrite(2'd2, 32'h1);
      avsRead(2'd2, rd);  checkOutput("ctrl_readback", rd, {31'd0, IRQ_ON});
      avsRead(2'd1, rd);  checkOutput("status_irq_en", rd, IRQ_ON ? 32'h8 : 32'h0);
      applyStimulus(32'h5);
      repeat (2) @(negedge clk);
      checkOutput("irq_set", {31'd0, irq}, {31'd0, IRQ_ON});
      avsRead(2'd0, rd);  checkOutput("irq_drain_data", rd, 32'h5);
      repeat (2) @(negedge clk);
      checkOutput("irq_clear", {31'd0, irq}, 32'd0);
      avsWrite(2'd2, 32'h0);

      // Reset mid-burst with a read pending
      #1 aso_ready = 1'b0;
      avsWrite(2'd0, 32'hA1); avsWrite(2'd0, 32'hA2);
      applyStimulus(32'hB1);
      @(posedge clk); #1;
      avs_address = 2'd1; avs_read = 1'b1; reset_reset = 1'b1;
      @(posedge clk); #1;
      avs_read = 1'b0;
      checkOutput("rst_no_valid", {31'd0, avs_readdatavalid}, 32'd0);
      checkOutput("rst_readdata", avs_readdata, 32'h0);
      @(posedge clk); #1 reset_reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_rdvalid_after", {31'd0, avs_readdatavalid}, 32'd0);
      checkOutput("rst_aso_valid", {31'd0, aso_valid}, 32'd0);
      checkOutput("rst_asi_ready", {31'd0, asi_ready}, 32'd1);
      avsRead(2'd1, rd);  checkOutput("rst_status", rd, 32'h0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
